// File: rtl/mem_ctrl_pkg.sv
// Shared CPU definitions for the memory-bus initiator.
// Contents: LSU length encodings, FSM state and owner encodings, default bus
// parameters, and byte-lane helpers used by the word assembler.
package cpu_defs;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_IF_BYTES   = 4;

  localparam logic [1:0] LEN_B = 2'd0;
  localparam logic [1:0] LEN_H = 2'd1;
  localparam logic [1:0] LEN_W = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_LSU = 1'b1
  } owner_t;

  // Byte count of an LSU access; encoding 3 behaves as a word.
  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    logic [2:0] n;
    case (len)
      LEN_B:   n = 3'd1;
      LEN_H:   n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

  // Replace byte lane 'lane' of a little-endian word.
  function automatic logic [31:0] put_byte(input logic [31:0] word,
                                           input logic [1:0]  lane,
                                           input logic [7:0]  data);
    logic [31:0] res;
    res = word;
    res[{lane, 3'b000} +: 8] = data;
    return res;
  endfunction

  // Extract byte lane 'lane' of a little-endian word.
  function automatic logic [7:0] get_byte(input logic [31:0] word,
                                          input logic [1:0]  lane);
    return word[{lane, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Request and memory-bus signal bundle for mem_ctrl.
// master: the bus initiator (takes fetch/LSU requests, drives the byte bus).
// slave : the surrounding system (requesters plus RAM / I/O responder).
//   fetch : if_valid, if_addr, if_flush -> if_done, if_data
//   lsu   : lsu_valid, lsu_wr, lsu_len, lsu_addr, lsu_wdata -> lsu_done, lsu_rdata
//   memory: mem_din -> mem_dout, mem_a, mem_wr
interface mem_ctrl_if
  import cpu_defs::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
  logic                  if_valid;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_flush;
  logic                  if_done;
  logic [31:0]           if_data;

  logic                  lsu_valid;
  logic                  lsu_wr;
  logic [1:0]            lsu_len;
  logic [ADDR_WIDTH-1:0] lsu_addr;
  logic [31:0]           lsu_wdata;
  logic                  lsu_done;
  logic [31:0]           lsu_rdata;

  logic [7:0]            mem_din;
  logic [7:0]            mem_dout;
  logic [ADDR_WIDTH-1:0] mem_a;
  logic                  mem_wr;

  modport master (
    input  if_valid, if_addr, if_flush,
    output if_done, if_data,
    input  lsu_valid, lsu_wr, lsu_len, lsu_addr, lsu_wdata,
    output lsu_done, lsu_rdata,
    input  mem_din,
    output mem_dout, mem_a, mem_wr
  );

  modport slave (
    output if_valid, if_addr, if_flush,
    input  if_done, if_data,
    output lsu_valid, lsu_wr, lsu_len, lsu_addr, lsu_wdata,
    input  lsu_done, lsu_rdata,
    output mem_din,
    input  mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-bus initiator: serialises instruction fetches and load/stores onto a
// single-byte memory bus whose responder has one cycle of read latency.
// Ports: clk_in (clock), rst_in (sync active-high reset), rdy_in (1 = CPU owns
// the bus), bus (mem_ctrl_if.master: request handshakes and byte bus).
// The LSU wins arbitration; a held fetch is served after the LSU's DONE cycle.
module mem_ctrl
  import cpu_defs::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int IF_BYTES   = DEF_IF_BYTES
) (
  input  logic      clk_in,
  input  logic      rst_in,
  input  logic      rdy_in,
  mem_ctrl_if.master bus
);

  localparam logic [2:0] FETCH_LEN = 3'(IF_BYTES);

  state_t                r_state;
  owner_t                r_owner;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [2:0]            r_len;
  logic [2:0]            r_iss_idx;   // next byte to put on the bus
  logic [2:0]            r_cap_idx;   // next byte to capture
  logic                  r_iss_vld;   // an address was issued at the last edge
  logic                  r_dat_vld;   // mem_din this cycle belongs to byte r_cap_idx
  logic [31:0]           r_buf;
  logic [ADDR_WIDTH-1:0] r_mem_a;
  logic [7:0]            r_mem_dout;
  logic                  r_mem_wr;
  logic                  r_if_done;
  logic                  r_lsu_done;
  logic [31:0]           r_if_data;
  logic [31:0]           r_lsu_rdata;

  logic                  w_take_lsu;
  logic                  w_take_if;
  logic [31:0]           w_cap_word;
  logic                  w_last_cap;
  logic [2:0]            w_next_idx;

  // Arbitration and byte-lane assembly helpers.
  always_comb begin
    w_take_lsu = bus.lsu_valid;
    w_take_if  = bus.if_valid & ~bus.if_flush & ~bus.lsu_valid;
    w_cap_word = put_byte(r_buf, r_cap_idx[1:0], bus.mem_din);
    w_last_cap = ((r_cap_idx + 3'd1) == r_len);
    w_next_idx = r_iss_idx + 3'd1;
  end

  // Transaction FSM with registered bus and handshake outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state     <= ST_IDLE;
      r_owner     <= OWN_IF;
      r_addr      <= '0;
      r_wdata     <= 32'd0;
      r_len       <= 3'd0;
      r_iss_idx   <= 3'd0;
      r_cap_idx   <= 3'd0;
      r_iss_vld   <= 1'b0;
      r_dat_vld   <= 1'b0;
      r_buf       <= 32'd0;
      r_mem_a     <= '0;
      r_mem_dout  <= 8'd0;
      r_mem_wr    <= 1'b0;
      r_if_done   <= 1'b0;
      r_lsu_done  <= 1'b0;
      r_if_data   <= 32'd0;
      r_lsu_rdata <= 32'd0;
    end else begin
      r_if_done  <= 1'b0;
      r_lsu_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (rdy_in && (w_take_lsu || w_take_if)) begin
            r_buf     <= 32'd0;   // bytes above N-1 read back as zero
            r_cap_idx <= 3'd0;
            r_dat_vld <= 1'b0;
            if (w_take_lsu) begin
              r_owner <= OWN_LSU;
              r_addr  <= bus.lsu_addr;
              r_len   <= len_bytes(bus.lsu_len);
              r_wdata <= bus.lsu_wdata;
              r_mem_a <= bus.lsu_addr;
              if (bus.lsu_wr) begin
                r_state    <= ST_WRITE;
                r_mem_dout <= bus.lsu_wdata[7:0];
                r_mem_wr   <= 1'b1;
                r_iss_idx  <= 3'd0;
                r_iss_vld  <= 1'b0;
              end else begin
                r_state   <= ST_READ;
                r_iss_idx <= 3'd1;
                r_iss_vld <= 1'b1;
              end
            end else begin
              r_owner   <= OWN_IF;
              r_addr    <= bus.if_addr;
              r_len     <= FETCH_LEN;
              r_mem_a   <= bus.if_addr;
              r_state   <= ST_READ;
              r_iss_idx <= 3'd1;
              r_iss_vld <= 1'b1;
            end
          end
        end
        ST_READ: begin
          if ((r_owner == OWN_IF) && bus.if_flush) begin
            r_state   <= ST_IDLE;
            r_iss_vld <= 1'b0;
            r_dat_vld <= 1'b0;
          end else if (!rdy_in) begin
            // Host owns the bus: rewind issue to the first byte not yet captured.
            r_iss_idx <= r_cap_idx;
            r_iss_vld <= 1'b0;
            r_dat_vld <= 1'b0;
          end else begin
            r_dat_vld <= r_iss_vld;
            if (r_iss_idx < r_len) begin
              r_mem_a   <= r_addr + ADDR_WIDTH'(r_iss_idx);
              r_iss_idx <= w_next_idx;
              r_iss_vld <= 1'b1;
            end else begin
              r_iss_vld <= 1'b0;
            end
            if (r_dat_vld) begin
              r_buf     <= w_cap_word;
              r_cap_idx <= r_cap_idx + 3'd1;
              if (w_last_cap) begin
                r_state <= ST_DONE;
                if (r_owner == OWN_IF) begin
                  r_if_done <= 1'b1;
                  r_if_data <= w_cap_word;
                end else begin
                  r_lsu_done  <= 1'b1;
                  r_lsu_rdata <= w_cap_word;
                end
              end
            end
          end
        end
        ST_WRITE: begin
          // A byte counts as written only at an edge where the CPU owns the bus.
          if (rdy_in) begin
            if (w_next_idx < r_len) begin
              r_iss_idx  <= w_next_idx;
              r_mem_a    <= r_addr + ADDR_WIDTH'(w_next_idx);
              r_mem_dout <= get_byte(r_wdata, w_next_idx[1:0]);
            end else begin
              r_mem_wr   <= 1'b0;
              r_state    <= ST_DONE;
              r_lsu_done <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state  <= ST_IDLE;
          r_mem_wr <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_a     = r_mem_a;
  assign bus.mem_dout  = r_mem_dout;
  assign bus.mem_wr    = r_mem_wr;
  assign bus.if_done   = r_if_done;
  assign bus.if_data   = r_if_data;
  assign bus.lsu_done  = r_lsu_done;
  assign bus.lsu_rdata = r_lsu_rdata;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: byte-wide RAM with registered reads,
// per-scenario tasks, and a queue of expected completions.
module tb_mem_ctrl;
  import cpu_defs::*;

  logic clk_in = 1'b0;
  logic rst_in;
  logic rdy_in;

  mem_ctrl_if #(.ADDR_WIDTH(32)) bus ();

  mem_ctrl #(.ADDR_WIDTH(32), .IF_BYTES(4)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    bit          is_if;
    bit          chk;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_mis = 0;

  logic [7:0]  ram [0:262143];
  logic        pl_en;
  logic [17:0] pl_addr;
  logic [7:0]  pl_data;

  // RAM / I/O responder: registered read, write committed only when the CPU owns the bus.
  always @(posedge clk_in) begin
    if (pl_en) begin
      ram[pl_addr] = pl_data;
    end else if (rdy_in) begin
      bus.mem_din <= ram[bus.mem_a[17:0]];
      if (bus.mem_wr) ram[bus.mem_a[17:0]] = bus.mem_dout;
    end else begin
      bus.mem_din <= 8'($urandom);
    end
  end

  task automatic preload(input logic [31:0] a, input logic [7:0] d);
    pl_addr = a[17:0];
    pl_data = d;
    pl_en   = 1'b1;
    @(posedge clk_in); #1;
    pl_en   = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk_in); #1;
    @(negedge clk_in);
    n_vec++; if (bus.mem_a !== 32'd0) begin n_mis++; $display("FAIL reset_mem_a got %h want 0", bus.mem_a); end
    n_vec++; if (bus.mem_dout !== 8'd0) begin n_mis++; $display("FAIL reset_mem_dout got %h want 0", bus.mem_dout); end
    n_vec++; if (bus.mem_wr !== 1'b0) begin n_mis++; $display("FAIL reset_mem_wr got %b want 0", bus.mem_wr); end
    n_vec++; if (bus.if_done !== 1'b0 || bus.lsu_done !== 1'b0) begin n_mis++; $display("FAIL reset_done got %b%b want 00", bus.if_done, bus.lsu_done); end
    n_vec++; if (bus.if_data !== 32'd0 || bus.lsu_rdata !== 32'd0) begin n_mis++; $display("FAIL reset_data got %h/%h want 0", bus.if_data, bus.lsu_rdata); end
    n_vec++; if (dut.r_state !== ST_IDLE) begin n_mis++; $display("FAIL reset_state got %0d want IDLE", dut.r_state); end
    @(posedge clk_in); #1;
    rst_in = 1'b0;
  endtask

  task automatic test_fetch();
    exp_t        e;
    int          n_addr;
    logic [31:0] prev_a;
    logic [31:0] want_a;
    @(posedge clk_in); #1;
    prev_a = bus.mem_a;
    n_addr = 0;
    bus.if_valid = 1'b1;
    bus.if_addr  = 32'h0000_0100;
    sb.push_back('{is_if: 1'b1, chk: 1'b1, data: 32'h0000_0513});
    @(posedge clk_in);  // E0
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_in);
      if (bus.mem_a !== prev_a) n_addr++;
      prev_a = bus.mem_a;
      want_a = (k < 4) ? 32'h100 + 32'(k) : 32'h103;
      n_vec++; if (bus.mem_a !== want_a) begin n_mis++; $display("FAIL fetch_addr k=%0d got %h want %h", k, bus.mem_a, want_a); end
      n_vec++; if (bus.if_done !== (k == 5)) begin n_mis++; $display("FAIL fetch_done k=%0d got %b want %b", k, bus.if_done, (k == 5)); end
      if (k < 5) @(posedge clk_in);
    end
    if (bus.if_done === 1'b1) begin
      e = sb.pop_front();
      n_vec++; if (!e.is_if || bus.if_data !== e.data) begin n_mis++; $display("FAIL fetch_data got %h want %h", bus.if_data, e.data); end
    end
    bus.if_valid = 1'b0;
    n_vec++; if (n_addr !== 4) begin n_mis++; $display("FAIL fetch_addr_count got %0d want 4", n_addr); end
  endtask

  task automatic test_store();
    exp_t        e;
    logic [31:0] wd;
    wd = 32'hDEAD_BEEF;
    @(posedge clk_in); #1;
    bus.lsu_valid = 1'b1; bus.lsu_wr = 1'b1; bus.lsu_len = LEN_W;
    bus.lsu_addr  = 32'h0000_0200; bus.lsu_wdata = wd;
    sb.push_back('{is_if: 1'b0, chk: 1'b0, data: 32'd0});
    @(posedge clk_in);  // E0
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_in);
      n_vec++; if (bus.mem_wr !== (k < 4)) begin n_mis++; $display("FAIL store_wr k=%0d got %b want %b", k, bus.mem_wr, (k < 4)); end
      if (k < 4) begin
        n_vec++; if (bus.mem_a !== 32'h200 + 32'(k) || bus.mem_dout !== wd[8*k +: 8]) begin
          n_mis++; $display("FAIL store_byte k=%0d got %h:%h want %h:%h", k, bus.mem_a, bus.mem_dout, 32'h200 + 32'(k), wd[8*k +: 8]);
        end
      end
      n_vec++; if (bus.lsu_done !== (k == 4)) begin n_mis++; $display("FAIL store_done k=%0d got %b", k, bus.lsu_done); end
      if (k < 4) @(posedge clk_in);
    end
    if (bus.lsu_done === 1'b1) begin
      e = sb.pop_front();
      n_vec++; if (e.is_if) begin n_mis++; $display("FAIL store_owner got lsu want fetch"); end
    end
    bus.lsu_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_vec++; if (ram[18'h200 + 18'(k)] !== wd[8*k +: 8]) begin n_mis++; $display("FAIL store_ram k=%0d got %h want %h", k, ram[18'h200 + 18'(k)], wd[8*k +: 8]); end
    end
  endtask

  task automatic test_load_half();
    exp_t        e;
    logic [31:0] want_a;
    @(posedge clk_in); #1;
    bus.lsu_valid = 1'b1; bus.lsu_wr = 1'b0; bus.lsu_len = LEN_H; bus.lsu_addr = 32'h0001_FFFF;
    sb.push_back('{is_if: 1'b0, chk: 1'b1, data: 32'h0000_1234});
    @(posedge clk_in);  // E0
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_in);
      want_a = (k == 0) ? 32'h0001_FFFF : 32'h0002_0000;
      n_vec++; if (bus.mem_a !== want_a) begin n_mis++; $display("FAIL half_addr k=%0d got %h want %h", k, bus.mem_a, want_a); end
      n_vec++; if (bus.lsu_done !== (k == 3)) begin n_mis++; $display("FAIL half_done k=%0d got %b", k, bus.lsu_done); end
      if (k < 3) @(posedge clk_in);
    end
    if (bus.lsu_done === 1'b1) begin
      e = sb.pop_front();
      n_vec++; if (e.is_if || bus.lsu_rdata !== e.data) begin n_mis++; $display("FAIL half_data got %h want %h", bus.lsu_rdata, e.data); end
    end
    bus.lsu_valid = 1'b0;
  endtask

  task automatic test_arbitrate();
    exp_t e;
    @(posedge clk_in); #1;
    bus.if_valid  = 1'b1; bus.if_addr = 32'h0000_0400;
    bus.lsu_valid = 1'b1; bus.lsu_wr = 1'b0; bus.lsu_len = LEN_B; bus.lsu_addr = 32'h0000_0300;
    sb.push_back('{is_if: 1'b0, chk: 1'b1, data: 32'h0000_0080});
    sb.push_back('{is_if: 1'b1, chk: 1'b1, data: 32'h4433_2211});
    @(posedge clk_in);  // E0
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_in);
      n_vec++; if (bus.lsu_done !== (k == 2)) begin n_mis++; $display("FAIL arb_lsu_done k=%0d got %b", k, bus.lsu_done); end
      n_vec++; if (bus.if_done !== (k == 9)) begin n_mis++; $display("FAIL arb_if_done k=%0d got %b", k, bus.if_done); end
      if (k == 3) begin
        n_vec++; if (bus.mem_a !== 32'h300) begin n_mis++; $display("FAIL arb_idle_addr got %h want 300", bus.mem_a); end
      end
      if (k == 4) begin
        n_vec++; if (bus.mem_a !== 32'h400) begin n_mis++; $display("FAIL arb_fetch_start got %h want 400", bus.mem_a); end
      end
      if (bus.lsu_done === 1'b1 || bus.if_done === 1'b1) begin
        e = sb.pop_front();
        n_vec++;
        if (e.is_if !== bus.if_done || (bus.if_done ? bus.if_data : bus.lsu_rdata) !== e.data) begin
          n_mis++; $display("FAIL arb_data k=%0d got if=%b %h/%h want if=%b %h", k, bus.if_done, bus.if_data, bus.lsu_rdata, e.is_if, e.data);
        end
        if (bus.lsu_done === 1'b1) bus.lsu_valid = 1'b0;
        if (bus.if_done === 1'b1) bus.if_valid = 1'b0;
      end
      if (k < 9) @(posedge clk_in);
    end
    bus.if_valid = 1'b0; bus.lsu_valid = 1'b0;
  endtask

  task automatic test_rdy_stall();
    exp_t e;
    int   done_e;
    done_e = -1;
    @(posedge clk_in); #1;
    bus.if_valid = 1'b1; bus.if_addr = 32'h0000_0500;
    sb.push_back('{is_if: 1'b1, chk: 1'b1, data: 32'hDDCC_BBAA});
    @(posedge clk_in);  // E0
    for (int k = 0; k < 16; k++) begin
      #1;
      if (k == 3) rdy_in = 1'b0;
      if (k == 6) rdy_in = 1'b1;
      @(negedge clk_in);
      if (k == 7) begin
        n_vec++; if (bus.mem_a !== 32'h502) begin n_mis++; $display("FAIL stall_reissue got %h want 502", bus.mem_a); end
      end
      if (k == 8) begin
        n_vec++; if (bus.mem_a !== 32'h503) begin n_mis++; $display("FAIL stall_next got %h want 503", bus.mem_a); end
      end
      if (bus.if_done === 1'b1) begin
        done_e = k;
        e = sb.pop_front();
        n_vec++; if (!e.is_if || bus.if_data !== e.data) begin n_mis++; $display("FAIL stall_data got %h want %h", bus.if_data, e.data); end
        bus.if_valid = 1'b0;
        break;
      end
      @(posedge clk_in);
    end
    rdy_in = 1'b1;
    bus.if_valid = 1'b0;
    n_vec++; if (done_e !== 10) begin n_mis++; $display("FAIL stall_done_time got %0d want 10", done_e); end
  endtask

  task automatic test_flush();
    exp_t e;
    @(posedge clk_in); #1;
    bus.if_valid = 1'b1; bus.if_addr = 32'h0000_0600;
    @(posedge clk_in);  // E0
    for (int k = 0; k < 8; k++) begin
      #1;
      if (k == 2) bus.if_flush = 1'b1;
      if (k == 3) begin
        bus.if_flush = 1'b0; bus.if_valid = 1'b0;
        bus.lsu_valid = 1'b1; bus.lsu_wr = 1'b1; bus.lsu_len = LEN_B;
        bus.lsu_addr = 32'h0000_0700; bus.lsu_wdata = 32'h0000_005A;
        sb.push_back('{is_if: 1'b0, chk: 1'b0, data: 32'd0});
      end
      @(negedge clk_in);
      n_vec++; if (bus.if_done !== 1'b0) begin n_mis++; $display("FAIL flush_if_done k=%0d got 1 want 0", k); end
      if (k == 3) begin
        n_vec++; if (dut.r_state !== ST_IDLE) begin n_mis++; $display("FAIL flush_state got %0d want IDLE", dut.r_state); end
      end
      if (k == 4) begin
        n_vec++; if (bus.mem_wr !== 1'b1 || bus.mem_a !== 32'h700 || bus.mem_dout !== 8'h5A) begin
          n_mis++; $display("FAIL flush_store_start got wr=%b %h:%h want wr=1 700:5a", bus.mem_wr, bus.mem_a, bus.mem_dout);
        end
      end
      n_vec++; if (bus.lsu_done !== (k == 5)) begin n_mis++; $display("FAIL flush_store_done k=%0d got %b", k, bus.lsu_done); end
      if (bus.lsu_done === 1'b1) begin
        e = sb.pop_front();
        n_vec++; if (e.is_if) begin n_mis++; $display("FAIL flush_owner got lsu want fetch"); end
        bus.lsu_valid = 1'b0;
      end
      @(posedge clk_in);
    end
    bus.lsu_valid = 1'b0;
    n_vec++; if (ram[18'h700] !== 8'h5A) begin n_mis++; $display("FAIL flush_ram got %h want 5a", ram[18'h700]); end
  endtask

  task automatic test_reset_mid_store();
    logic [31:0] want;
    @(posedge clk_in); #1;
    bus.lsu_valid = 1'b1; bus.lsu_wr = 1'b1; bus.lsu_len = LEN_W;
    bus.lsu_addr = 32'h0000_0800; bus.lsu_wdata = 32'hCAFE_F00D;
    @(posedge clk_in); #1;  // E0
    rst_in = 1'b1;
    @(posedge clk_in); #1;  // E1
    rst_in = 1'b0;
    bus.lsu_valid = 1'b0;
    @(negedge clk_in);
    n_vec++; if (bus.mem_a !== 32'd0 || bus.mem_dout !== 8'd0 || bus.mem_wr !== 1'b0) begin
      n_mis++; $display("FAIL rst_mid_outputs got %h:%h wr=%b want 0", bus.mem_a, bus.mem_dout, bus.mem_wr);
    end
    n_vec++; if (dut.r_state !== ST_IDLE) begin n_mis++; $display("FAIL rst_mid_state got %0d want IDLE", dut.r_state); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_in);
      n_vec++; if (bus.lsu_done !== 1'b0 || bus.mem_wr !== 1'b0) begin n_mis++; $display("FAIL rst_mid_quiet k=%0d got done=%b wr=%b", k, bus.lsu_done, bus.mem_wr); end
    end
    want = 32'h0000_000D;
    for (int k = 0; k < 4; k++) begin
      n_vec++; if (ram[18'h800 + 18'(k)] !== want[8*k +: 8]) begin n_mis++; $display("FAIL rst_mid_ram k=%0d got %h want %h", k, ram[18'h800 + 18'(k)], want[8*k +: 8]); end
    end
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; pl_en = 1'b0; pl_addr = 18'd0; pl_data = 8'd0;
    bus.if_valid = 1'b0; bus.if_addr = 32'd0; bus.if_flush = 1'b0;
    bus.lsu_valid = 1'b0; bus.lsu_wr = 1'b0; bus.lsu_len = 2'd0;
    bus.lsu_addr = 32'd0; bus.lsu_wdata = 32'd0;
    preload(32'h100, 8'h13);   preload(32'h101, 8'h05);
    preload(32'h102, 8'h00);   preload(32'h103, 8'h00);
    preload(32'h1FFFF, 8'h34); preload(32'h20000, 8'h12);
    preload(32'h300, 8'h80);
    preload(32'h400, 8'h11);   preload(32'h401, 8'h22);
    preload(32'h402, 8'h33);   preload(32'h403, 8'h44);
    preload(32'h500, 8'hAA);   preload(32'h501, 8'hBB);
    preload(32'h502, 8'hCC);   preload(32'h503, 8'hDD);
    preload(32'h700, 8'h00);
    preload(32'h800, 8'h00);   preload(32'h801, 8'h00);
    preload(32'h802, 8'h00);   preload(32'h803, 8'h00);
    test_reset();
    test_fetch();
    test_store();
    test_load_half();
    test_arbitrate();
    test_rdy_stall();
    test_flush();
    test_reset_mid_store();
    n_vec++; if (sb.size() != 0) begin n_mis++; $display("FAIL scoreboard_left got %0d want 0", sb.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
